// File: rtl/pipeline_ctrl_fsm.sv
// Pipeline stall/flush controller for the 5-stage core.
// Arbitrates load-use, branch redirect, multi-cycle data-memory and MUL/DIV
// stall sources by fixed priority. Also owns the data-memory wait FSM, the
// memory-timeout watchdog and a saturating stall-cycle performance counter.
// All stall/flush/dmem_req outputs are combinational from state and inputs.
//
// Handshake: dmem_req is raised in the cycle the MEM stage presents an access
// and is held every cycle until the cycle in which dmem_ack is high. The
// access completes in that ack cycle, and no stall is applied in it.
module pipeline_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use,
    input  logic             branch_taken,
    input  logic             mem_access,
    input  logic             dmem_ack,
    input  logic             md_start,
    input  logic             md_done,
    input  logic             cnt_clr,
    output logic             pc_stall,
    output logic             if_stall,
    output logic             id_stall,
    output logic             ex_stall,
    output logic             mem_stall,
    output logic             if_flush,
    output logic             id_flush,
    output logic             ex_flush,
    output logic             mem_flush,
    output logic             dmem_req,
    output logic [1:0]       state,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WC_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_MD_WAIT  = 2'd2,
        ST_FAULT    = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WC_W-1:0]   r_wait_cnt;
    logic [WC_W-1:0]   w_wait_cnt_nxt;
    logic              w_timeout_set;
    logic              r_mem_timeout;
    logic [CNT_W-1:0]  r_stall_cycles;

    // Ungated control outputs; forced low while reset is asserted.
    logic w_pc_stall, w_if_stall, w_id_stall, w_ex_stall, w_mem_stall;
    logic w_if_flush, w_id_flush, w_ex_flush, w_mem_flush, w_dmem_req;

    // State register, wait counter and sticky watchdog flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (w_timeout_set) begin
                r_mem_timeout <= 1'b1;
            end
        end
    end

    // Next-state logic: memory wait has priority over MUL/DIV wait in RUN.
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_timeout_set  = 1'b0;
        unique case (r_state)
            ST_RUN: begin
                if (mem_access && !dmem_ack) begin
                    w_state_nxt    = ST_MEM_WAIT;
                    w_wait_cnt_nxt = '0;
                end else if (md_start && !md_done) begin
                    w_state_nxt = ST_MD_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ack) begin
                    w_state_nxt = ST_RUN;
                end else if (r_wait_cnt == WC_LAST) begin
                    w_state_nxt   = ST_FAULT;
                    w_timeout_set = 1'b1;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 1'b1;
                end
            end
            ST_MD_WAIT: begin
                if (md_done) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_FAULT;
            end
        endcase
    end

    // Output logic: stall/flush/request decode from state and live inputs.
    always_comb begin
        w_pc_stall  = 1'b0;
        w_if_stall  = 1'b0;
        w_id_stall  = 1'b0;
        w_ex_stall  = 1'b0;
        w_mem_stall = 1'b0;
        w_if_flush  = 1'b0;
        w_id_flush  = 1'b0;
        w_ex_flush  = 1'b0;
        w_mem_flush = 1'b0;
        w_dmem_req  = 1'b0;
        unique case (r_state)
            ST_RUN: begin
                if (mem_access) begin
                    w_dmem_req = 1'b1;
                end
                if (mem_access && !dmem_ack) begin
                    // Whole pipe holds while the first memory cycle is outstanding.
                    w_pc_stall  = 1'b1;
                    w_if_stall  = 1'b1;
                    w_id_stall  = 1'b1;
                    w_ex_stall  = 1'b1;
                    w_mem_stall = 1'b1;
                end else if (md_start && !md_done) begin
                    w_pc_stall  = 1'b1;
                    w_if_stall  = 1'b1;
                    w_id_stall  = 1'b1;
                    w_ex_stall  = 1'b1;
                    w_mem_flush = 1'b1;
                end else if (branch_taken) begin
                    // Branch wins over load-use: the ID instruction is wrong-path.
                    w_if_flush = 1'b1;
                    w_id_flush = 1'b1;
                end else if (load_use) begin
                    w_pc_stall = 1'b1;
                    w_if_stall = 1'b1;
                    w_id_stall = 1'b1;
                    w_ex_flush = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                w_dmem_req = 1'b1;
                if (!dmem_ack) begin
                    w_pc_stall  = 1'b1;
                    w_if_stall  = 1'b1;
                    w_id_stall  = 1'b1;
                    w_ex_stall  = 1'b1;
                    w_mem_stall = 1'b1;
                end
            end
            ST_MD_WAIT: begin
                if (!md_done) begin
                    w_pc_stall  = 1'b1;
                    w_if_stall  = 1'b1;
                    w_id_stall  = 1'b1;
                    w_ex_stall  = 1'b1;
                    w_mem_flush = 1'b1;
                end
            end
            default: begin
                // FAULT: freeze the pipe and drop the memory request.
                w_pc_stall  = 1'b1;
                w_if_stall  = 1'b1;
                w_id_stall  = 1'b1;
                w_ex_stall  = 1'b1;
                w_mem_stall = 1'b1;
            end
        endcase
    end

    // Saturating stall-cycle counter; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
        end else if (cnt_clr) begin
            r_stall_cycles <= '0;
        end else if (pc_stall && (r_stall_cycles != {CNT_W{1'b1}})) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    assign pc_stall     = rst_n & w_pc_stall;
    assign if_stall     = rst_n & w_if_stall;
    assign id_stall     = rst_n & w_id_stall;
    assign ex_stall     = rst_n & w_ex_stall;
    assign mem_stall    = rst_n & w_mem_stall;
    assign if_flush     = rst_n & w_if_flush;
    assign id_flush     = rst_n & w_id_flush;
    assign ex_flush     = rst_n & w_ex_flush;
    assign mem_flush    = rst_n & w_mem_flush;
    assign dmem_req     = rst_n & w_dmem_req;
    assign state        = r_state;
    assign mem_timeout  = r_mem_timeout;
    assign stall_cycles = r_stall_cycles;

endmodule
